// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/done handshake.
// Optional leading-zero blanking output enabled by defining BIN2BCD_SEQ_BLANK_EN.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef BIN2BCD_SEQ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               ovf_work_q, ovf_work_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   adj_c;

    // Add-3 correction on every digit of the work register; digits are independent.
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end else begin
                adj_c[4*i +: 4] = work_q[4*i +: 4];
            end
        end
    end

`ifdef BIN2BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic [DIGITS-1:0]  blank_c;

    // A digit blanks when it and every higher digit are zero; the units digit always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_c    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (work_q[4*i +: 4] == 4'd0);
            blank_c[i] = zero_above;
        end
        blank_c[0] = 1'b0;
        if (ovf_work_q) begin
            blank_c = '0;
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
`ifdef BIN2BCD_SEQ_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_W'(BIN_W);
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d     = {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d      = {bin_q[BIN_W-2:0], 1'b0};
                ovf_work_d = ovf_work_q | adj_c[BCD_W-1];
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                bcd_d   = work_q;
                ovf_d   = ovf_work_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
`ifdef BIN2BCD_SEQ_BLANK_EN
                blank_d = blank_c;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef BIN2BCD_SEQ_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
`ifdef BIN2BCD_SEQ_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
`ifdef BIN2BCD_SEQ_BLANK_EN
    assign blank    = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: three instances (8b/3d, 8b/2d, 16b/5d).
// Checks blank only when BIN2BCD_SEQ_BLANK_EN is defined.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bin_v = '0;
    logic        st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;
`ifdef BIN2BCD_SEQ_BLANK_EN
    logic [2:0]  blank_a;
    logic [1:0]  blank_b;
    logic [4:0]  blank_c;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .bin_in(bin_v[7:0]),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
`ifdef BIN2BCD_SEQ_BLANK_EN
        , .blank(blank_a)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .bin_in(bin_v[7:0]),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
`ifdef BIN2BCD_SEQ_BLANK_EN
        , .blank(blank_b)
`endif
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st_c), .bin_in(bin_v),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c)
`ifdef BIN2BCD_SEQ_BLANK_EN
        , .blank(blank_c)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reference by repeated division.
    function automatic logic [63:0] to_bcd(input int unsigned v, input int unsigned digits);
        logic [63:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < int'(digits); d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic [63:0] bcd_of(input int sel);
        case (sel)
            0: return 64'(bcd_a);
            1: return 64'(bcd_b);
            default: return 64'(bcd_c);
        endcase
    endfunction

    function automatic logic ovf_of(input int sel);
        case (sel)
            0: return ovf_a;
            1: return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    // Edges until done is seen, counted from the accepting edge; -1 on timeout.
    task automatic wait_done(input int sel, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done_of(sel)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_conv(input int sel, input logic [15:0] v, output int lat);
        @(negedge clk);
        bin_v = v;
        case (sel)
            0: st_a = 1'b1;
            1: st_b = 1'b1;
            default: st_c = 1'b1;
        endcase
        @(posedge clk);
        #1;
        st_a = 1'b0;
        st_b = 1'b0;
        st_c = 1'b0;
        wait_done(sel, lat);
    endtask

    initial begin
        int lat;
        int ndone;

        #12;
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_done", 64'(done_a), 64'd0);
        check("reset_bcd", 64'(bcd_a), 64'd0);
        check("reset_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 255 on the 8b/3d instance
        run_conv(0, 16'd255, lat);
        check("lat_255", 64'(lat), 64'd9);
        check("bcd_255", bcd_of(0), 64'h255);
        check("ovf_255", 64'(ovf_a), 64'd0);
`ifdef BIN2BCD_SEQ_BLANK_EN
        check("blank_255", 64'(blank_a), 64'b000);
`endif
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done_a), 64'd0);
        check("idle_busy", 64'(busy_a), 64'd0);
        check("hold_bcd", bcd_of(0), 64'h255);

        run_conv(0, 16'd0, lat);
        check("bcd_0", bcd_of(0), 64'h000);
`ifdef BIN2BCD_SEQ_BLANK_EN
        check("blank_0", 64'(blank_a), 64'b110);
`endif
        run_conv(0, 16'd7, lat);
        check("bcd_7", bcd_of(0), 64'h007);
`ifdef BIN2BCD_SEQ_BLANK_EN
        check("blank_7", 64'(blank_a), 64'b110);
`endif

        // Exhaustive back-to-back with start held high
        @(negedge clk);
        bin_v = 16'd0;
        st_a = 1'b1;
        for (int v = 0; v < 256; v++) begin
            @(posedge clk);
            #1;
            check("b2b_accept", 64'(busy_a), 64'd1);
            wait_done(0, lat);
            check("b2b_lat", 64'(lat), 64'd9);
            check("b2b_bcd", bcd_of(0), to_bcd(v, 3));
            bin_v = 16'(v + 1);
            if (v == 255) st_a = 1'b0;
        end

        // start and bin_in changes during busy are ignored
        @(negedge clk);
        bin_v = 16'd200;
        st_a = 1'b1;
        @(posedge clk);
        #1;
        bin_v = 16'd99;
        repeat (6) @(posedge clk);
        #1;
        st_a = 1'b0;
        wait_done(0, lat);
        check("busy_ign_lat", 64'(lat), 64'd3);
        check("busy_ign_bcd", bcd_of(0), 64'h200);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        check("busy_ign_nodone", 64'(ndone), 64'd0);
        check("busy_ign_hold", bcd_of(0), 64'h200);

        // Reset mid-conversion
        @(negedge clk);
        bin_v = 16'd150;
        st_a = 1'b1;
        @(posedge clk);
        #1;
        st_a = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_bcd", bcd_of(0), 64'h000);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        check("rst_nodone", 64'(ndone), 64'd0);
        run_conv(0, 16'd42, lat);
        check("lat_42", 64'(lat), 64'd9);
        check("bcd_42", bcd_of(0), 64'h042);
`ifdef BIN2BCD_SEQ_BLANK_EN
        check("blank_42", 64'(blank_a), 64'b100);
`endif

        // Two-digit instance: overflow boundaries
        run_conv(1, 16'd255, lat);
        check("d2_bcd_255", bcd_of(1), 64'h55);
        check("d2_ovf_255", 64'(ovf_of(1)), 64'd1);
`ifdef BIN2BCD_SEQ_BLANK_EN
        check("d2_blank_255", 64'(blank_b), 64'b00);
`endif
        run_conv(1, 16'd99, lat);
        check("d2_bcd_99", bcd_of(1), 64'h99);
        check("d2_ovf_99", 64'(ovf_of(1)), 64'd0);
        run_conv(1, 16'd100, lat);
        check("d2_bcd_100", bcd_of(1), 64'h00);
        check("d2_ovf_100", 64'(ovf_of(1)), 64'd1);

        // 16-bit, five-digit instance
        run_conv(2, 16'd65535, lat);
        check("w16_lat", 64'(lat), 64'd17);
        check("w16_bcd_65535", bcd_of(2), 64'h65535);
        check("w16_ovf", 64'(ovf_of(2)), 64'd0);
`ifdef BIN2BCD_SEQ_BLANK_EN
        check("w16_blank", 64'(blank_c), 64'b00000);
`endif
        run_conv(2, 16'd10000, lat);
        check("w16_bcd_10000", bcd_of(2), 64'h10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
